// File: rtl/pipe_ctrl_pkg.sv
// Shared types and instruction constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2,
    STEP   = 3'd3,
    DRESET = 3'd4
  } ctrl_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode-stage instruction that reads the destination of the load now in stage 2.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_instr_ex,
  output logic        o_hazard
);

  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_op_id;
  logic       w_ex_load;
  logic       w_rs1_used;
  logic       w_rs2_used;

  assign w_rd    = i_instr_ex[11:7];
  assign w_rs1   = i_instr_id[19:15];
  assign w_rs2   = i_instr_id[24:20];
  assign w_op_id = i_instr_id[6:0];

  assign w_ex_load = (i_instr_ex != NOP) && (i_instr_ex[6:0] == OP_LOAD) && (w_rd != 5'd0);

  // U-type and JAL carry immediate bits in the rs1 field, so they never read it.
  assign w_rs1_used = (w_op_id != OP_LUI) && (w_op_id != OP_AUIPC) && (w_op_id != OP_JAL);
  assign w_rs2_used = (w_op_id == OP_RTYPE) || (w_op_id == OP_STORE) || (w_op_id == OP_BRANCH);

  assign o_hazard = w_ex_load && (i_instr_id != NOP) &&
                    ((w_rs1_used && (w_rs1 == w_rd)) || (w_rs2_used && (w_rs2 == w_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 3-stage core: load-use bubbles, branch squash,
// and debugger halt/step/resume/reset sequencing.
//
//   state  | meaning
//   RUN    | normal execution, hazard and branch handling active
//   DRAIN  | injecting NOPs before declaring the core halted
//   HALTED | core quiescent, debugger owns the state
//   STEP   | one cycle of free-running to release a single instruction
//   DRESET | debugger-requested reset of all stage registers
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] NOP          = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  input  logic        br_taken,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume_req,
  input  logic        dbg_step_req,
  input  logic        dbg_reset_req,
  output logic        stall_if,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        reset_stages,
  output logic        halted,
  output logic        step_done
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] RESET_LAST = 4'(RESET_CYCLES - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_cnt_inc;
  logic        r_step_flag;
  logic        w_step_flag_nxt;
  logic        r_step_pulse;
  logic        w_step_pulse_nxt;
  logic        w_hazard;

  load_use_detect #(
    .NOP (NOP)
  ) u_load_use_detect (
    .i_instr_id (instr_id),
    .i_instr_ex (instr_ex),
    .o_hazard   (w_hazard)
  );

  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= RUN;
      r_cnt        <= 4'd0;
      r_step_flag  <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_step_flag  <= w_step_flag_nxt;
      r_step_pulse <= w_step_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_step_flag_nxt  = r_step_flag;
    w_step_pulse_nxt = 1'b0;
    if (dbg_reset_req) begin
      w_state_nxt     = DRESET;
      w_cnt_nxt       = 4'd0;
      w_step_flag_nxt = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (dbg_halt_req) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = 4'd0;
          end
        end
        DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            w_state_nxt      = HALTED;
            w_step_pulse_nxt = r_step_flag;
            w_step_flag_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HALTED: begin
          if (dbg_resume_req) begin
            w_state_nxt = RUN;
          end else if (dbg_step_req) begin
            w_state_nxt = STEP;
          end
        end
        STEP: begin
          w_state_nxt     = DRAIN;
          w_cnt_nxt       = 4'd0;
          w_step_flag_nxt = 1'b1;
        end
        DRESET: begin
          if (r_cnt == RESET_LAST) begin
            w_state_nxt = dbg_halt_req ? HALTED : RUN;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_if     = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    reset_stages = 1'b0;
    halted       = 1'b0;
    step_done    = 1'b0;
    if (!reset_n) begin
      reset_stages = 1'b1;
    end else begin
      case (r_state)
        RUN, STEP: begin
          // A taken branch squashes the dependent instruction, so no bubble is needed.
          if (br_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (w_hazard) begin
            stall_if = 1'b1;
            flush_ex = 1'b1;
          end
        end
        DRAIN: begin
          stall_if = 1'b1;
          flush_ex = 1'b1;
          flush_id = br_taken;
        end
        HALTED: begin
          stall_if  = 1'b1;
          stall_ex  = 1'b1;
          halted    = 1'b1;
          step_done = r_step_pulse;
        end
        DRESET: begin
          reset_stages = 1'b1;
          stall_if     = 1'b1;
        end
        default: begin
          reset_stages = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_pipeline_ctrl;

  localparam int          DRAIN_N = 2;
  localparam int          RESET_N = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_X1   = 32'h0000_A083;
  localparam logic [31:0] LW_X0   = 32'h0000_A003;
  localparam logic [31:0] ADD_X1  = 32'h0010_8133;
  localparam logic [31:0] ADD_X0  = 32'h0000_0133;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3, M_DRESET = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_id;
  logic [31:0] instr_ex;
  logic        br_taken;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_step_req;
  logic        dbg_reset_req;
  logic        stall_if;
  logic        stall_ex;
  logic        flush_id;
  logic        flush_ex;
  logic        reset_stages;
  logic        halted;
  logic        step_done;

  int n_checks = 0;
  int n_fails  = 0;

  int m_mode = M_RUN;
  int m_left = 0;
  bit m_stepping = 0;
  bit m_pulse = 0;

  logic [6:0] obs;
  logic [6:0] exp_v;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .DRAIN_CYCLES (DRAIN_N),
    .RESET_CYCLES (RESET_N),
    .NOP          (NOP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_id       (instr_id),
    .instr_ex       (instr_ex),
    .br_taken       (br_taken),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_step_req   (dbg_step_req),
    .dbg_reset_req  (dbg_reset_req),
    .stall_if       (stall_if),
    .stall_ex       (stall_ex),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .reset_stages   (reset_stages),
    .halted         (halted),
    .step_done      (step_done)
  );

  assign obs = {stall_if, stall_ex, flush_id, flush_ex, reset_stages, halted, step_done};

  function automatic bit model_hazard(input logic [31:0] id, input logic [31:0] ex);
    logic [4:0] rd;
    logic [6:0] op;
    bit         rs1_read;
    bit         rs2_read;
    rd = ex[11:7];
    op = id[6:0];
    if (id == NOP || ex == NOP) return 0;
    if (ex[6:0] != 7'h03 || rd == 5'd0) return 0;
    rs1_read = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    rs2_read = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return (rs1_read && id[19:15] == rd) || (rs2_read && id[24:20] == rd);
  endfunction

  // {stall_if, stall_ex, flush_id, flush_ex, reset_stages, halted, step_done}
  function automatic logic [6:0] model_expect();
    logic [6:0] e;
    e = 7'b0;
    if (!reset_n) begin
      e[2] = 1'b1;
    end else if (m_mode == M_RUN || m_mode == M_STEP) begin
      if (br_taken) e = 7'b0011000;
      else if (model_hazard(instr_id, instr_ex)) e = 7'b1001000;
    end else if (m_mode == M_DRAIN) begin
      e = {1'b1, 1'b0, br_taken, 1'b1, 3'b000};
    end else if (m_mode == M_HALTED) begin
      e = {6'b110001, m_pulse};
    end else begin
      e = 7'b1000100;
    end
    return e;
  endfunction

  function automatic void model_advance();
    bit pulse_next;
    pulse_next = 0;
    if (!reset_n) begin
      m_mode = M_RUN;
      m_stepping = 0;
    end else if (dbg_reset_req) begin
      m_mode = M_DRESET;
      m_left = RESET_N;
      m_stepping = 0;
    end else begin
      case (m_mode)
        M_RUN: if (dbg_halt_req) begin m_mode = M_DRAIN; m_left = DRAIN_N; end
        M_DRAIN: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_HALTED;
            pulse_next = m_stepping;
            m_stepping = 0;
          end
        end
        M_HALTED: begin
          if (dbg_resume_req) m_mode = M_RUN;
          else if (dbg_step_req) m_mode = M_STEP;
        end
        M_STEP: begin m_mode = M_DRAIN; m_left = DRAIN_N; m_stepping = 1; end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = dbg_halt_req ? M_HALTED : M_RUN;
        end
      endcase
    end
    m_pulse = pulse_next;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
    dbg_resume_req = 1'b0;
    dbg_step_req   = 1'b0;
    dbg_reset_req  = 1'b0;
  endtask

  task automatic idle_inputs();
    instr_id = NOP; instr_ex = NOP; br_taken = 1'b0;
    dbg_halt_req = 1'b0; dbg_resume_req = 1'b0; dbg_step_req = 1'b0; dbg_reset_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    instr_ex = LW_X1; instr_id = ADD_X1; br_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin reset_n = 1'b1; idle_inputs(); end
      @(negedge clk);
      exp_v = model_expect();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL reset cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    for (int i = 0; i < 4; i++) begin
      instr_id = ADD_X1;
      instr_ex = (i == 0) ? LW_X1 : NOP;
      if (i == 2) begin instr_ex = LW_X0; instr_id = ADD_X0; end
      @(negedge clk);
      exp_v = model_expect();
      stalls += int'(stall_if);
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL load_use cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (stalls != 1) begin
      n_fails++;
      $display("FAIL load_use_bubbles: got %0d stall cycles expected 1", stalls);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    for (int i = 0; i < 2; i++) begin
      instr_ex = LW_X1; instr_id = ADD_X1; br_taken = (i == 0);
      @(negedge clk);
      exp_v = model_expect();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL branch_vs_hazard cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_halt_resume();
    dbg_halt_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin dbg_halt_req = 1'b0; dbg_resume_req = 1'b1; end
      @(negedge clk);
      exp_v = model_expect();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL halt_resume cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (halted !== 1'b0) begin
      n_fails++;
      $display("FAIL resume_running: halted got %b expected 0", halted);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    dbg_halt_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) dbg_step_req = 1'b1;
      if (i == 10) begin dbg_step_req = 1'b1; dbg_resume_req = 1'b1; dbg_halt_req = 1'b0; end
      @(negedge clk);
      exp_v = model_expect();
      pulses += int'(step_done);
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL single_step cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fails++;
      $display("FAIL step_done_count: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_dbg_reset();
    int resets = 0;
    dbg_halt_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) dbg_reset_req = 1'b1;
      if (i == 6) dbg_halt_req = 1'b0;
      if (i == 7) dbg_reset_req = 1'b1;
      @(negedge clk);
      exp_v = model_expect();
      resets += int'(reset_stages);
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL dbg_reset cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (resets != 2 * RESET_N) begin
      n_fails++;
      $display("FAIL dbg_reset_len: got %0d reset cycles expected %0d", resets, 2 * RESET_N);
    end
  endtask

  function automatic logic [31:0] rand_instr(input bit want_load);
    logic [6:0] ops [8];
    logic [6:0] op;
    ops = '{7'h03, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
    op = want_load ? 7'h03 : ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 9) == 0) return NOP;
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) dbg_halt_req = ~dbg_halt_req;
      dbg_resume_req = ($urandom_range(0, 9) == 0);
      dbg_step_req   = ($urandom_range(0, 7) == 0);
      dbg_reset_req  = ($urandom_range(0, 39) == 0);
      br_taken       = ($urandom_range(0, 5) == 0);
      instr_ex       = rand_instr($urandom_range(0, 1) == 1);
      instr_id       = rand_instr(1'b0);
      @(negedge clk);
      exp_v = model_expect();
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL random cyc%0d: outputs got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_halt_resume();
    test_step();
    test_dbg_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
